// File: rtl/ask_frame_serializer.sv
// Purpose : frames bytes as on-off-keyed bits (preamble, start, 8 data LSB-first, [parity], stop) for the DDS ASK modulator.
// Latency : byte accepted at edge E0 -> first frame bit on o_data after E1; every bit lasts CLKS_PER_BIT clocks.
// Backpr. : one-entry holding buffer; o_ready low while it is full, source must hold i_valid until accepted.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_byte, i_valid     payload byte and its valid strobe
//   o_ready             holding buffer empty (byte accepted on i_valid && o_ready)
//   o_data              registered keying bit (1 = carrier on)
//   o_busy              a frame is on the line
//   o_frame_done        one-cycle pulse after a stop bit completes
//
// Build option: define ASK_PARITY_EN to append an even-parity bit after the data bits.
module ask_frame_serializer #(
  parameter int CLKS_PER_BIT  = 1024,
  parameter int PREAMBLE_BITS = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_byte,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_data,
  output logic       o_busy,
  output logic       o_frame_done
);

  localparam int CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
  // With no preamble this value is never compared against, the state is unreachable.
  localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  localparam state_t FIRST_STATE = (PREAMBLE_BITS > 0) ? S_PREAMBLE : S_START;

  state_t           r_state;
  logic [CYC_W-1:0] r_cyc;
  logic [5:0]       r_bit;
  logic [7:0]       r_shift;
  logic [7:0]       r_hold;
  logic             r_hold_full;
  logic             r_data;
  logic             r_done;

  state_t           w_state_nxt;
  logic [CYC_W-1:0] w_cyc_nxt;
  logic [5:0]       w_bit_nxt;
  logic [7:0]       w_shift_nxt;
  logic             w_load;
  logic             w_data_nxt;
  logic             w_done_nxt;
  logic             w_bit_end;
  logic             w_accept;

`ifdef ASK_PARITY_EN
  logic             r_par;
`endif

  assign w_bit_end = (r_cyc == CYC_LAST);
  // Buffer can only accept while empty and only loads while full, so accept and load never collide.
  assign w_accept  = i_valid & ~r_hold_full;

  assign o_ready      = ~r_hold_full;
  assign o_data       = r_data;
  assign o_busy       = (r_state != S_IDLE);
  assign o_frame_done = r_done;

  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_load      = 1'b0;
    w_done_nxt  = 1'b0;

    if (r_state != S_IDLE) begin
      w_cyc_nxt = w_bit_end ? '0 : r_cyc + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (r_hold_full) w_load = 1'b1;
      end
      S_PREAMBLE: begin
        if (w_bit_end) begin
          if (r_bit == PRE_LAST) begin
            w_state_nxt = S_START;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + 6'd1;
          end
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 6'd7) begin
`ifdef ASK_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
            w_bit_nxt = '0;
          end else begin
            w_bit_nxt = r_bit + 6'd1;
          end
        end
      end
`ifdef ASK_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) w_state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_done_nxt = 1'b1;
          // A waiting byte starts its preamble on the very next cycle: no idle gap.
          if (r_hold_full) w_load = 1'b1;
          else             w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_load) begin
      w_state_nxt = FIRST_STATE;
      w_cyc_nxt   = '0;
      w_bit_nxt   = '0;
      w_shift_nxt = r_hold;
    end

    // o_data is registered, so it is derived from where the FSM is going.
    case (w_state_nxt)
      S_PREAMBLE: w_data_nxt = ~w_bit_nxt[0];
      S_START:    w_data_nxt = 1'b1;
      S_DATA:     w_data_nxt = w_shift_nxt[0];
`ifdef ASK_PARITY_EN
      S_PARITY:   w_data_nxt = r_par;
`endif
      default:    w_data_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cyc       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_data      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cyc       <= w_cyc_nxt;
      r_bit       <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_data      <= w_data_nxt;
      r_done      <= w_done_nxt;
      r_hold_full <= w_accept | (r_hold_full & ~w_load);
      if (w_accept) r_hold <= i_byte;
    end
  end

`ifdef ASK_PARITY_EN
  // Even parity of the byte being loaded, sampled alongside the shifter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_par <= 1'b0;
    else if (w_load) r_par <= ^r_hold;
  end
`endif

endmodule
